// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and control states shared by the execute-stage ALU.
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SRA1 = 4'b1000;
    localparam logic [3:0] OP_SLL1 = 4'b1001;
    localparam logic [3:0] OP_SRL1 = 4'b1010;
    localparam logic [3:0] OP_SLLV = 4'b1011;
    localparam logic [3:0] OP_ROL1 = 4'b1100;
    localparam logic [3:0] OP_ROR1 = 4'b1101;
    localparam logic [3:0] OP_SRLV = 4'b1110;
    localparam logic [3:0] OP_SRAV = 4'b1111;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational result and unknown-op flag for every single-cycle ALU op.
module alu_comb
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   func_i,
    output logic [W-1:0] res_o,
    output logic         err_o
);
    logic [SHW-1:0] sh;
    assign sh = b_i[SHW-1:0];

    always_comb begin
        res_o = '0;
        err_o = 1'b0;
        case (func_i)
            OP_ADD:  res_o = a_i + b_i;
            OP_SUB:  res_o = a_i - b_i;
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_NOT:  res_o = ~a_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_SRA1: res_o = {a_i[W-1], a_i[W-1:1]};
            OP_SRL1: res_o = {1'b0, a_i[W-1:1]};
            OP_SLL1: res_o = {a_i[W-2:0], 1'b0};
            OP_ROL1: res_o = {a_i[W-2:0], a_i[W-1]};
            OP_ROR1: res_o = {a_i[0], a_i[W-1:1]};
            OP_SLLV: res_o = a_i << sh;
            OP_SRLV: res_o = a_i >> sh;
            OP_SRAV: res_o = $signed(a_i) >>> sh;
            // Multiply is sequenced by the stage; it is a known op here.
            OP_MUL:  res_o = '0;
            default: err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_stage_mc.sv
// alu_stage_mc: registered execute-stage ALU with valid/ready handshake and
// an iterative shift-add multiplier that stalls issue while it runs.
module alu_stage_mc
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] RF_A,
    input  logic [W-1:0] RF_B,
    input  logic [W-1:0] immed,
    input  logic         Bsel,
    input  logic [3:0]   func,
    input  logic         flush,
    output logic         out_valid,
    output logic [W-1:0] ALU_out,
    output logic         zero,
    output logic         op_err
);
    localparam int CW = $clog2(W) + 1;

    state_t        state_q, state_d;
    logic [W-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d, err_q, err_d, vld_q, vld_d;
    logic [W-1:0]  op_b, comb_res, acc_next;
    logic          comb_err, accept;

    assign op_b      = Bsel ? immed : RF_B;
    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready && !flush;
    assign acc_next  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign ALU_out   = res_q;
    assign zero      = zero_q;
    assign op_err    = err_q;
    assign out_valid = vld_q;

    alu_comb #(.W(W), .SHW(SHW)) u_comb (
        .a_i    (RF_A),
        .b_i    (op_b),
        .func_i (func),
        .res_o  (comb_res),
        .err_o  (comb_err)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        zero_d   = zero_q;
        err_d    = err_q;
        vld_d    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (accept && func == OP_MUL) begin
                state_d  = ST_MUL;
                mcand_d  = RF_A;
                mplier_d = op_b;
                acc_d    = '0;
                cnt_d    = CW'(W);
            end else if (accept) begin
                res_d  = comb_res;
                zero_d = ~|comb_res;
                err_d  = comb_err;
                vld_d  = 1'b1;
            end
        end else if (flush) begin
            // Abort wins over completion; the result register is left untouched.
            state_d  = ST_IDLE;
            mcand_d  = '0;
            mplier_d = '0;
            acc_d    = '0;
            cnt_d    = '0;
        end else begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = ST_IDLE;
                res_d   = acc_next;
                zero_d  = ~|acc_next;
                err_d   = 1'b0;
                vld_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            vld_q    <= vld_d;
        end
    end
endmodule

// File: tb/tb_alu_stage_mc.sv
// tb_alu_stage_mc: directed vectors feed a scoreboard queue; a negedge monitor
// pops and compares every out_valid result.
module tb_alu_stage_mc;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        e;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n, in_valid, Bsel, flush;
    logic [31:0] RF_A, RF_B, immed;
    logic [3:0]  func;
    logic        in_ready, out_valid, zero, op_err;
    logic [31:0] ALU_out;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;

    alu_stage_mc #(.W(32)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .RF_A      (RF_A),
        .RF_B      (RF_B),
        .immed     (immed),
        .Bsel      (Bsel),
        .func      (func),
        .flush     (flush),
        .out_valid (out_valid),
        .ALU_out   (ALU_out),
        .zero      (zero),
        .op_err    (op_err)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Reset_n && out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got ALU_out=%h zero=%b op_err=%b, expected no out_valid", ALU_out, zero, op_err);
            end else begin
                e = q.pop_front();
                if ({ALU_out, zero, op_err} !== e) begin
                    errors++;
                    $display("FAIL result: got ALU_out=%h zero=%b op_err=%b, expected ALU_out=%h zero=%b op_err=%b",
                             ALU_out, zero, op_err, e.r, e.z, e.e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Presents one op and returns 1ns after its accept edge.
    task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic bs, input logic pu, input logic [31:0] r, input logic er);
        int n = 0;
        func = f;
        RF_A = a;
        Bsel = bs;
        RF_B  = bs ? 32'hDEAD_BEEF : b;
        immed = bs ? b : 32'hDEAD_BEEF;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        if (pu) q.push_back({r, (r == 32'd0), er});
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic ov1, ov2, rdy_bad, unchanged;
        logic [31:0] held;
        Reset_n = 1'b0; in_valid = 1'b0; Bsel = 1'b0; flush = 1'b0;
        RF_A = '0; RF_B = '0; immed = '0; func = OP_ADD;
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();

        // 1: reset in the middle of a multiply clears a prior result
        send(OP_ADD, 32'd1, 32'd2, 1'b0, 1'b1, 32'd3, 1'b0);
        tick();
        send(OP_MUL, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (4) tick();
        #2 Reset_n = 1'b0;
        #1 chk("reset_outputs", {28'd0, out_valid, zero, op_err, 1'b0} | ALU_out, 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_alu_out", ALU_out, 32'd0);

        // 2: wrap-around add then back-to-back subtract
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd0, 1'b0);
        ov1 = out_valid;
        send(OP_SUB, 32'd5, 32'd5, 1'b0, 1'b1, 32'd0, 1'b0);
        ov2 = out_valid;
        chk("b2b_out_valid", {30'd0, ov1, ov2}, 32'd3);

        // 3: shifts, rotates, logic ops
        send(OP_SRAV, 32'h8000_0000, 32'd4, 1'b0, 1'b1, 32'hF800_0000, 1'b0);
        send(OP_SLLV, 32'd1, 32'd35, 1'b1, 1'b1, 32'd8, 1'b0);
        send(OP_ROL1, 32'h8000_0001, 32'd0, 1'b0, 1'b1, 32'h0000_0003, 1'b0);
        send(OP_ROR1, 32'h0000_0003, 32'd0, 1'b0, 1'b1, 32'h8000_0001, 1'b0);
        send(OP_SRA1, 32'h8000_0004, 32'd0, 1'b0, 1'b1, 32'hC000_0002, 1'b0);
        send(OP_SRL1, 32'h8000_0004, 32'd0, 1'b0, 1'b1, 32'h4000_0002, 1'b0);
        send(OP_SLL1, 32'h8000_0001, 32'd0, 1'b0, 1'b1, 32'h0000_0002, 1'b0);
        send(OP_SRLV, 32'h8000_0000, 32'd31, 1'b0, 1'b1, 32'd1, 1'b0);
        send(OP_SRAV, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        send(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b1, 32'h0FF0_0FF0, 1'b0);
        send(OP_NOT, 32'h0000_FFFF, 32'd0, 1'b0, 1'b1, 32'hFFFF_0000, 1'b0);
        send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b1, 32'hF000_F000, 1'b0);
        send(OP_OR, 32'hF0F0_F0F0, 32'h0F00_0000, 1'b0, 1'b1, 32'hFFF0_F0F0, 1'b0);

        // 4: multiply latency and wrap
        send(OP_MUL, 32'd7, 32'd6, 1'b0, 1'b1, 32'd42, 1'b0);
        n = 1;
        rdy_bad = 1'b0;
        while (!out_valid && n < 60) begin
            if (in_ready) rdy_bad = 1'b1;
            tick();
            n++;
        end
        chk("mul_ready_low", {31'd0, rdy_bad}, 32'd0);
        chk("mul_latency", n, 32'd33);
        tick();
        send(OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        tick();

        // 5: flush an in-flight multiply, then a flushed idle input, then ADD
        held = ALU_out;
        send(OP_MUL, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (8) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b1;
        func = OP_ADD; RF_A = 32'd1; Bsel = 1'b0; RF_B = 32'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        unchanged = 1'b1;
        repeat (40) begin
            if (ALU_out !== held || out_valid) unchanged = 1'b0;
            tick();
        end
        chk("flush_hold", {31'd0, unchanged}, 32'd1);
        send(OP_ADD, 32'd3, 32'd4, 1'b0, 1'b1, 32'd7, 1'b0);

        // 6: unknown op flags and clears
        send(4'b0111, 32'h1234_5678, 32'h1, 1'b0, 1'b1, 32'd0, 1'b1);
        send(OP_ADD, 32'd3, 32'd4, 1'b0, 1'b1, 32'd7, 1'b0);
        tick();
        chk("op_err_cleared", {31'd0, op_err}, 32'd0);
        repeat (3) tick();
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_stage_mc.md
Name: alu_stage_mc

Overview:
Parametrised, registered successor of the execute-stage ALU. It has the same operand mux (register B or immediate), keeps the existing 4-bit function encoding, and adds XOR, variable shifts and an iterative shift-add multiplier. A valid/ready handshake lets the multi-cycle multiply stall the issuing stage. It sits between register-read and memory/writeback.

Parameters:
W, 32, datapath width; power of 2, at least 8.
SHW, $clog2(W), width of the shift-amount field taken from the low bits of the B operand.

Ports:
Clk  in  1  clock, rising edge.
Reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operands and func are presented.
in_ready  out  1  stage can accept; combinational, equal to (state == IDLE).
RF_A  in  W  operand A.
RF_B  in  W  register operand B.
immed  in  W  immediate operand.
Bsel  in  1  0 selects RF_B, 1 selects immed.
func  in  4  operation code.
flush  in  1  abort the in-flight operation and drop the current input.
out_valid  out  1  one-cycle pulse when ALU_out/zero/op_err are updated.
ALU_out  out  W  registered result; holds until the next result.
zero  out  1  registered; equals ~|ALU_out for every op.
op_err  out  1  registered; 1 when the accepted func is unknown.

Behaviour:
- Reset (asynchronous, any state, mid-multiply included): state=IDLE; ALU_out=0, zero=0, op_err=0, out_valid=0; multiplier registers cleared.
- Operand B is the Bsel mux output. Accept happens on a rising edge where in_valid && in_ready && !flush.
- Single-cycle ops, latency 1: result is registered on the accept edge, with out_valid=1 for the following cycle. Back-to-back accepts every cycle are allowed.
  - 0000 A+B (wraps mod 2^W)
  - 0001 A-B
  - 0010 A&B
  - 0011 A|B
  - 0100 ~A
  - 0110 A^B
  - 1000 arithmetic shift right by 1
  - 1010 logical shift right by 1
  - 1001 logical shift left by 1
  - 1100 rotate left by 1
  - 1101 rotate right by 1
  - 1011 shift left by B[SHW-1:0]
  - 1110 logical shift right by B[SHW-1:0]
  - 1111 arithmetic shift right by B[SHW-1:0]
  - Shift amount 0 returns A unchanged.
- 0101 MUL: unsigned multiply, result is the low W bits. States: IDLE, MUL.
  - On the accept edge: mcand=A, mplier=B, acc=0, cnt=W; state goes to MUL.
  - Each edge in MUL: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt -= 1.
  - On the edge where cnt goes 1->0: ALU_out = final acc, out_valid=1 next cycle, state goes to IDLE.
  - Latency is fixed at W+1 edges from accept to result register; there is no early exit.
  - in_ready=0 for all of MUL. The first new accept can occur on the same edge that MUL completes only if in_ready was already 1 in that cycle, which it is not. The next accept is therefore at least one cycle after the result.
- Unknown func (0111): ALU_out=0, zero=1, op_err=1, out_valid=1, latency 1.
- op_err clears on the next accepted valid op.
- flush:
  - In MUL: next edge returns to IDLE, no out_valid, ALU_out keeps its previous value.
  - In IDLE: the input that cycle is not accepted.
  - flush has priority over completion on the same edge.
- out_valid deasserts in every cycle not immediately after a result update. Outputs are never changed by un-accepted inputs.

Decomposition:
- Package alu_pkg holds:
  - 4-bit op constants: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_MUL, OP_XOR, OP_SRA1, OP_SLL1, OP_SRL1, OP_SLLV, OP_ROL1, OP_ROR1, OP_SRLV, OP_SRAV.
  - state enum {ST_IDLE, ST_MUL}.
- One sub-module, alu_comb (parameter W): purely combinational. It computes result and unknown-op flag for all single-cycle ops.
- alu_stage_mc holds the mux, handshake, FSM, multiplier datapath and output registers.

Test Plan:
1. Reset_n low mid-operation, then release -> all outputs 0, in_ready=1 on the first cycle after release.
2. ADD 0xFFFFFFFF+1 (Bsel=1, immed=1), then back-to-back SUB 5-5 -> ALU_out=0 zero=1 one cycle after each accept; out_valid high for two consecutive cycles.
3. SRAV A=0x80000000 B=4 -> 0xF8000000. SLLV A=1 B=35 -> 0x00000008 (amount masked to 3). ROL1 A=0x80000001 -> 0x00000003.
4. MUL 7*6 -> in_ready low for 32 cycles, ALU_out=42 with out_valid exactly 33 edges after accept (accept edge counted as edge 1). MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
5. flush at cycle 10 of a MUL, then ADD 3+4 -> no out_valid for the MUL, ADD gives 7, ALU_out unchanged in between.
6. func=0111 -> op_err=1 zero=1 ALU_out=0. Next ADD clears op_err.
